// File: rtl/pump_scheduler_pkg.sv
// Shared encodings and widths for the diffuser pump scheduler.
// State codes double as the debug/LCD encoding on state_out.
package pump_sched_pkg;

    localparam int REMAIN_W = 13;
    localparam int PHASE_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPRAY  = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_MANUAL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SCENT_COTTON  = 2'd0,
        SCENT_WOODY   = 2'd1,
        SCENT_CITRUS  = 2'd2,
        SCENT_INVALID = 2'd3
    } scent_t;

    typedef enum logic [1:0] {
        TIMER_T0      = 2'd0,
        TIMER_T1      = 2'd1,
        TIMER_T2      = 2'd2,
        TIMER_INVALID = 2'd3
    } timer_t;

    // Pump drive for a scent code; the invalid code drives nothing.
    function automatic logic [2:0] scent_onehot(input logic [1:0] scent);
        return 3'b001 << scent;
    endfunction

endpackage

// File: rtl/pump_scheduler_if.sv
// Command/menu inputs and pump/LCD outputs between the mode controller
// (master) and the pump scheduler (slave).
interface pump_scheduler_if;
    import pump_sched_pkg::*;

    logic                pump_on;
    logic                pump_off;
    logic                manual_on;
    logic [1:0]          scent_sel;
    logic [1:0]          timer_sel;
    logic [2:0]          pump_en;
    logic                running;
    logic [REMAIN_W-1:0] remain_sec;
    logic [1:0]          state_out;

    modport master (
        output pump_on, pump_off, manual_on, scent_sel, timer_sel,
        input  pump_en, running, remain_sec, state_out
    );

    modport slave (
        input  pump_on, pump_off, manual_on, scent_sel, timer_sel,
        output pump_en, running, remain_sec, state_out
    );

endinterface

// File: rtl/pump_scheduler_sec_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick
// for one cycle at terminal count. clr restarts the second from zero.
module sec_tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == TERM);

endmodule

// File: rtl/pump_scheduler.sv
// Diffuser pump session sequencer: spray/pause duty cycling for a timed
// session, single manual sprays, and remaining-time export for the LCD.
// Optional PUMP_SCHED_LIVE_SCENT_EN: scent re-sampled at each PAUSE->SPRAY.
module pump_scheduler
    import pump_sched_pkg::*;
#(
    parameter int TICK_DIV     = 1_000_000,
    parameter int SPRAY_SEC    = 5,
    parameter int INTERVAL_SEC = 60,
    parameter int T0_SEC       = 1800,
    parameter int T1_SEC       = 3600,
    parameter int T2_SEC       = 7200
) (
    input logic              clk,
    input logic              reset,
    pump_scheduler_if.slave  bus
);

    localparam logic [REMAIN_W-1:0] T0_LD    = REMAIN_W'(T0_SEC);
    localparam logic [REMAIN_W-1:0] T1_LD    = REMAIN_W'(T1_SEC);
    localparam logic [REMAIN_W-1:0] T2_LD    = REMAIN_W'(T2_SEC);
    localparam logic [REMAIN_W-1:0] ONE_R    = REMAIN_W'(1);
    localparam logic [PHASE_W-1:0]  SPRAY_LD = PHASE_W'(SPRAY_SEC);
    localparam logic [PHASE_W-1:0]  PAUSE_LD = PHASE_W'(INTERVAL_SEC - SPRAY_SEC);
    localparam logic [PHASE_W-1:0]  ONE_P    = PHASE_W'(1);

    if (T0_SEC > (1 << REMAIN_W) - 1 || T1_SEC > (1 << REMAIN_W) - 1 ||
        T2_SEC > (1 << REMAIN_W) - 1) begin : g_bad_session_len
        $error("session length does not fit remain_sec");
    end
    if (INTERVAL_SEC <= SPRAY_SEC || SPRAY_SEC < 1 ||
        INTERVAL_SEC - SPRAY_SEC > (1 << PHASE_W) - 1 ||
        SPRAY_SEC > (1 << PHASE_W) - 1) begin : g_bad_phase_len
        $error("spray/interval lengths invalid for phase counters");
    end

    state_t              state;
    logic [1:0]          scent_lat;
    logic [REMAIN_W-1:0] remain;
    logic [PHASE_W-1:0]  spray_cnt;
    logic [PHASE_W-1:0]  pause_cnt;
    logic [2:0]          pump_en_q;
    logic                running_q;

    logic                tick;
    logic                on_ok;
    logic                manual_ok;
    logic                tick_done;
    logic                to_idle;
    logic                tick_clr;
    logic                tick_en;
    logic [1:0]          spray_scent;
    logic [REMAIN_W-1:0] t_load;

    assign on_ok     = bus.pump_on && (bus.scent_sel != SCENT_INVALID) &&
                       (bus.timer_sel != TIMER_INVALID);
    assign manual_ok = bus.manual_on && (state == ST_IDLE) &&
                       (bus.scent_sel != SCENT_INVALID);

    // Session expiry outranks phase changes; manual ends on its last spray second.
    assign tick_done = tick && ((((state == ST_SPRAY) || (state == ST_PAUSE)) && remain == ONE_R) ||
                                ((state == ST_MANUAL) && spray_cnt == ONE_P));
    assign to_idle   = bus.pump_off || (!on_ok && tick_done);

    assign tick_clr  = bus.pump_off || on_ok || manual_ok;
    assign tick_en   = (state != ST_IDLE);

`ifdef PUMP_SCHED_LIVE_SCENT_EN
    assign spray_scent = (bus.scent_sel != SCENT_INVALID) ? bus.scent_sel : scent_lat;
`else
    assign spray_scent = scent_lat;
`endif

    // NOTE: every path assigns t_load (default first), so no latch is inferred.
    always_comb begin
        t_load = '0;
        unique case (bus.timer_sel)
            TIMER_T0: t_load = T0_LD;
            TIMER_T1: t_load = T1_LD;
            TIMER_T2: t_load = T2_LD;
            default:  t_load = '0;
        endcase
    end

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            scent_lat <= '0;
            remain    <= '0;
            spray_cnt <= '0;
            pause_cnt <= '0;
            pump_en_q <= '0;
            running_q <= 1'b0;
        end else if (to_idle) begin
            state     <= ST_IDLE;
            remain    <= '0;
            spray_cnt <= '0;
            pause_cnt <= '0;
            pump_en_q <= '0;
            running_q <= 1'b0;
        end else if (on_ok) begin
            state     <= ST_SPRAY;
            scent_lat <= bus.scent_sel;
            remain    <= t_load;
            spray_cnt <= SPRAY_LD;
            pause_cnt <= '0;
            pump_en_q <= scent_onehot(bus.scent_sel);
            running_q <= 1'b1;
        end else if (manual_ok) begin
            state     <= ST_MANUAL;
            scent_lat <= bus.scent_sel;
            spray_cnt <= SPRAY_LD;
            pump_en_q <= scent_onehot(bus.scent_sel);
            running_q <= 1'b1;
        end else if (tick) begin
            unique case (state)
                ST_SPRAY: begin
                    remain <= remain - ONE_R;
                    if (spray_cnt == ONE_P) begin
                        spray_cnt <= '0;
                        pause_cnt <= PAUSE_LD;
                        pump_en_q <= '0;
                        state     <= ST_PAUSE;
                    end else begin
                        spray_cnt <= spray_cnt - ONE_P;
                    end
                end
                ST_PAUSE: begin
                    remain <= remain - ONE_R;
                    if (pause_cnt == ONE_P) begin
                        pause_cnt <= '0;
                        spray_cnt <= SPRAY_LD;
                        scent_lat <= spray_scent;
                        pump_en_q <= scent_onehot(spray_scent);
                        state     <= ST_SPRAY;
                    end else begin
                        pause_cnt <= pause_cnt - ONE_P;
                    end
                end
                ST_MANUAL: spray_cnt <= spray_cnt - ONE_P;
                default: ;
            endcase
        end
    end

    assign bus.pump_en    = pump_en_q;
    assign bus.running    = running_q;
    assign bus.remain_sec = remain;
    assign bus.state_out  = state;

endmodule

// File: tb/tb_pump_scheduler.sv
// Self-checking bench for pump_scheduler: directed vector table, multi-cycle
// corner sequences, then randomized commands against a time-based model.
module tb_pump_scheduler;
    import pump_sched_pkg::*;

    localparam int TD = 10;
    localparam int SP = 2;
    localparam int IV = 5;
    localparam int T0 = 12;
    localparam int T1 = 20;
    localparam int T2 = 30;

`ifdef PUMP_SCHED_LIVE_SCENT_EN
    localparam bit LIVE = 1'b1;
`else
    localparam bit LIVE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pump_scheduler_if bus ();

    pump_scheduler #(
        .TICK_DIV     (TD),
        .SPRAY_SEC    (SP),
        .INTERVAL_SEC (IV),
        .T0_SEC       (T0),
        .T1_SEC       (T1),
        .T2_SEC       (T2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         on;
        bit         off;
        bit         man;
        logic [1:0] scent;
        logic [1:0] timer;
        int         wait_n;
        logic [2:0] en;
        bit         run;
        int         rem;
        int         st;
    } vec_t;

    vec_t vecs[$];

    typedef enum {M_IDLE, M_SESSION, M_MANUAL} mdl_mode_t;
    mdl_mode_t m_mode  = M_IDLE;
    int        m_start = 0;
    int        m_scent = 0;
    int        m_total = 0;
    int        now     = 0;

    task automatic check(input string name, input logic [2:0] exp_en, input logic exp_run,
                         input int exp_rem, input int exp_st);
        n_checks++;
        if (bus.pump_en !== exp_en || bus.running !== exp_run ||
            bus.remain_sec !== REMAIN_W'(exp_rem) || bus.state_out !== 2'(exp_st)) begin
            n_fail++;
            $display("FAIL %s: got pump_en=%b running=%b remain_sec=%0d state=%0d, want pump_en=%b running=%b remain_sec=%0d state=%0d",
                     name, bus.pump_en, bus.running, bus.remain_sec, bus.state_out,
                     exp_en, exp_run, exp_rem, exp_st);
        end
    endtask

    function automatic void add(input bit on, input bit off, input bit man, input logic [1:0] scent,
                                input logic [1:0] timer, input int wait_n, input logic [2:0] en,
                                input bit run, input int rem, input int st);
        vec_t v;
        v.on = on; v.off = off; v.man = man; v.scent = scent; v.timer = timer;
        v.wait_n = wait_n; v.en = en; v.run = run; v.rem = rem; v.st = st;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        bus.pump_on   = v.on;
        bus.pump_off  = v.off;
        bus.manual_on = v.man;
        bus.scent_sel = v.scent;
        bus.timer_sel = v.timer;
        @(posedge clk);
        #1;
        bus.pump_on   = 1'b0;
        bus.pump_off  = 1'b0;
        bus.manual_on = 1'b0;
        for (int i = 0; i < v.wait_n; i++) begin
            @(posedge clk);
            #1;
        end
        check($sformatf("vec%0d", idx), v.en, v.run, v.rem, v.st);
    endtask

    // Reference: a session is a start edge plus elapsed whole seconds; the
    // phase is elapsed seconds modulo the spray interval.
    task automatic model_step();
        int e;
        int s;
        now++;
        if (bus.pump_off) begin
            m_mode = M_IDLE;
        end else if (bus.pump_on && bus.scent_sel != 2'd3 && bus.timer_sel != 2'd3) begin
            m_mode  = M_SESSION;
            m_start = now;
            m_scent = int'(bus.scent_sel);
            m_total = (bus.timer_sel == 2'd0) ? T0 : (bus.timer_sel == 2'd1) ? T1 : T2;
        end else if (bus.manual_on && m_mode == M_IDLE && bus.scent_sel != 2'd3) begin
            m_mode  = M_MANUAL;
            m_start = now;
            m_scent = int'(bus.scent_sel);
        end else if (m_mode != M_IDLE) begin
            e = now - m_start;
            s = e / TD;
            if (m_mode == M_MANUAL) begin
                if (s >= SP) m_mode = M_IDLE;
            end else if (s >= m_total) begin
                m_mode = M_IDLE;
            end else if (LIVE && e % TD == 0 && s > 0 && s % IV == 0 && bus.scent_sel != 2'd3) begin
                m_scent = int'(bus.scent_sel);
            end
        end
    endtask

    task automatic model_check(input int c);
        int         s;
        logic [2:0] en;
        s  = (now - m_start) / TD;
        en = 3'b001 << m_scent;
        case (m_mode)
            M_SESSION: begin
                if (s % IV < SP) check($sformatf("rand%0d", c), en, 1'b1, m_total - s, 1);
                else             check($sformatf("rand%0d", c), 3'b000, 1'b1, m_total - s, 2);
            end
            M_MANUAL: check($sformatf("rand%0d", c), en, 1'b1, 0, 3);
            default:  check($sformatf("rand%0d", c), 3'b000, 1'b0, 0, 0);
        endcase
    endtask

    initial begin
        int n;
        int r;

        bus.pump_on   = 1'b0;
        bus.pump_off  = 1'b0;
        bus.manual_on = 1'b0;
        bus.scent_sel = 2'd0;
        bus.timer_sel = 2'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 3'b000, 1'b0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        //  on off man scent timer wait  en      run rem st
        add(1, 0, 0, 2'd1, 2'd0,  0, 3'b010, 1, 12, 1);
        add(0, 0, 0, 2'd1, 2'd0, 19, 3'b000, 1, 10, 2);
        add(0, 0, 0, 2'd1, 2'd0, 29, 3'b010, 1,  7, 1);
        add(0, 0, 0, 2'd1, 2'd0, 69, 3'b000, 0,  0, 0);
        add(0, 0, 0, 2'd1, 2'd0, 29, 3'b000, 0,  0, 0);
        add(1, 1, 0, 2'd1, 2'd0,  0, 3'b000, 0,  0, 0);
        add(1, 0, 0, 2'd0, 2'd3,  0, 3'b000, 0,  0, 0);
        add(1, 0, 0, 2'd3, 2'd0,  0, 3'b000, 0,  0, 0);
        add(0, 0, 1, 2'd2, 2'd0,  0, 3'b100, 1,  0, 3);
        add(0, 0, 0, 2'd2, 2'd0, 18, 3'b100, 1,  0, 3);
        add(0, 0, 0, 2'd2, 2'd0,  0, 3'b000, 0,  0, 0);
        add(1, 0, 0, 2'd2, 2'd1,  4, 3'b100, 1, 20, 1);
        add(0, 1, 0, 2'd2, 2'd1,  0, 3'b000, 0,  0, 0);
        add(1, 0, 0, 2'd0, 2'd0, 24, 3'b000, 1, 10, 2);
        add(0, 0, 1, 2'd1, 2'd0,  0, 3'b000, 1, 10, 2);
        add(0, 0, 0, 2'd2, 2'd0, 24, LIVE ? 3'b100 : 3'b001, 1, 7, 1);
        add(0, 0, 0, 2'd2, 2'd0, 19, 3'b000, 1,  5, 2);
        add(1, 0, 0, 2'd0, 2'd0,  0, 3'b001, 1, 12, 1);
        add(0, 0, 0, 2'd0, 2'd0,  8, 3'b001, 1, 12, 1);
        add(0, 0, 0, 2'd0, 2'd0,  0, 3'b001, 1, 11, 1);

        foreach (vecs[i]) apply(vecs[i], i);

        // Manual spray length measured with a bounded wait.
        @(negedge clk);
        bus.pump_off = 1'b1;
        @(negedge clk);
        bus.pump_off  = 1'b0;
        bus.manual_on = 1'b1;
        bus.scent_sel = 2'd0;
        @(posedge clk);
        #1;
        bus.manual_on = 1'b0;
        n = 0;
        while (bus.pump_en != 3'b000 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n != SP * TD) begin
            n_fail++;
            $display("FAIL manual_len: got %0d cycles, want %0d", n, SP * TD);
        end
        check("manual_end", 3'b000, 1'b0, 0, 0);

        // Asynchronous reset in the middle of a spray.
        @(negedge clk);
        bus.pump_on   = 1'b1;
        bus.scent_sel = 2'd1;
        bus.timer_sel = 2'd2;
        @(posedge clk);
        #1;
        bus.pump_on = 1'b0;
        check("pre_reset_spray", 3'b010, 1'b1, T2, 1);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", 3'b000, 1'b0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", 3'b000, 1'b0, 0, 0);

        // Randomized commands against the reference model.
        m_mode = M_IDLE;
        now    = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 999));
            bus.pump_off  = (r < 3);
            bus.pump_on   = (r >= 3 && r < 8);
            bus.manual_on = (r >= 8 && r < 18);
            if ($urandom_range(0, 199) == 0) begin
                bus.pump_on  = 1'b1;
                bus.pump_off = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) bus.scent_sel = 2'($urandom_range(0, 3));
            bus.timer_sel = 2'($urandom_range(0, 3));
            @(posedge clk);
            model_step();
            #1;
            model_check(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
